// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake,
// with a fixed number of wait states between request acceptance and commit.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q,   rsp_err_d;
    logic               busy_q,      busy_d;
    logic               we_q,        we_d;
    logic [31:0]        addr_q,      addr_d;
    logic [31:0]        wdata_q,     wdata_d;
    logic [3:0]         wstrb_q,     wstrb_d;

    logic               accept_c;
    logic               commit_c;
    logic               addr_err_c;
    logic               mem_we_c;
    logic [IDX_W-1:0]   idx_c;

    // Storage is deliberately left out of reset.
    logic [31:0] mem [DEPTH_WORDS];

    // Next-state, request capture and response formation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        commit_c    = 1'b0;

        accept_c   = req_valid && req_ready_q;
        addr_err_c = (addr_q[1:0] != 2'b00) ||
                     ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
        idx_c      = addr_q[IDX_W+1:2];

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The counter runs down to zero; the access commits on the edge after that.
                if (cnt_q == '0) begin
                    commit_c    = 1'b1;
                    state_d     = RESP;
                    rsp_err_d   = addr_err_c;
                    rsp_rdata_d = (addr_err_c || we_q) ? 32'd0 : mem[idx_c];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_we_c    = commit_c && we_q && !addr_err_c;
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset clears control and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    // Byte-lane write at commit time.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
